// File: rtl/pipeline_hazard_controller.sv
// Interlock controller for the IF/ID/EX/MEM/WB data path: shadows destination info of
// EX/MEM/WB and drives stall, bubble, forwarding, memory freeze, flush and write-back enable.

module phc_operand_chk #(
  parameter int REG_SEL_W = 2
) (
  input  logic                 src_en_i,
  input  logic [REG_SEL_W-1:0] src_sel_i,
  input  logic                 ex_ld_vld_i,
  input  logic [REG_SEL_W-1:0] ex_dst_sel_i,
  input  logic                 mem_wr_vld_i,
  input  logic                 mem_ld_i,
  input  logic [REG_SEL_W-1:0] mem_dst_sel_i,
  input  logic                 wb_wr_vld_i,
  input  logic [REG_SEL_W-1:0] wb_dst_sel_i,
  output logic [1:0]           fwd_sel_o,
  output logic                 ld_use_o
);
  logic ex_hit, mem_hit, wb_hit;

  assign ex_hit   = src_en_i && ex_ld_vld_i  && (ex_dst_sel_i  == src_sel_i);
  assign mem_hit  = src_en_i && mem_wr_vld_i && (mem_dst_sel_i == src_sel_i);
  assign wb_hit   = src_en_i && wb_wr_vld_i  && (wb_dst_sel_i  == src_sel_i);
  assign ld_use_o = ex_hit || (mem_hit && mem_ld_i);

  // Load data is not yet available in MEM, so a MEM load falls through to the WB source.
  always_comb begin
    fwd_sel_o = 2'b00;
    if (mem_hit && !mem_ld_i) fwd_sel_o = 2'b01;
    else if (wb_hit)          fwd_sel_o = 2'b10;
  end
endmodule

module pipeline_hazard_controller #(
  parameter int REG_SEL_W   = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 id_valid,
  input  logic                 id_src1_en,
  input  logic [REG_SEL_W-1:0] id_src1_sel,
  input  logic                 id_src2_en,
  input  logic [REG_SEL_W-1:0] id_src2_sel,
  input  logic                 id_dst_en,
  input  logic [REG_SEL_W-1:0] id_dst_sel,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 flush,
  input  logic                 mem_ready,
  output logic                 pc_hold,
  output logic                 if_id_hold,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_hold,
  output logic [1:0]           fwd_sel_1,
  output logic [1:0]           fwd_sel_2,
  output logic                 wb_enable,
  output logic [REG_SEL_W-1:0] wb_sel,
  output logic                 mem_error,
  output logic [CNT_W-1:0]     stall_count
);
  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
  localparam int NOPS  = 2;

  typedef struct packed {
    logic                 vld;
    logic                 dst_en;
    logic [REG_SEL_W-1:0] dst_sel;
    logic                 mem_rd;
    logic                 mem_wr;
  } stage_t;

  typedef struct packed {
    logic                 wr;
    logic [REG_SEL_W-1:0] dst_sel;
  } wb_stage_t;

  stage_t                  ex_q, ex_d, mem_q, mem_d;
  wb_stage_t               wbs_q, wbs_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    mem_err_q, mem_err_d;
  logic                    wb_en_q;
  logic [REG_SEL_W-1:0]    wb_sel_q;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

  logic                    mem_acc, frz, tmo, kill, ld_use;
  logic [NOPS-1:0]         src_en, ld_use_op;
  logic [NOPS-1:0][REG_SEL_W-1:0] src_sel;
  logic [NOPS-1:0][1:0]    fwd;

  assign mem_acc = mem_q.vld && (mem_q.mem_rd || mem_q.mem_wr);
  assign frz     = mem_acc && !mem_ready;
  assign tmo     = frz && (tmr_q == TMR_W'(MEM_TIMEOUT - 1));
  // A flush seen while frozen is held in flush_pend_q until the pipe moves again.
  assign kill    = !frz && (flush || flush_pend_q);

  assign src_en  = {id_src2_en, id_src1_en} & {NOPS{id_valid}};
  assign src_sel = {id_src2_sel, id_src1_sel};

  for (genvar g = 0; g < NOPS; g++) begin : g_op
    phc_operand_chk #(.REG_SEL_W(REG_SEL_W)) u_chk (
      .src_en_i      (src_en[g]),
      .src_sel_i     (src_sel[g]),
      .ex_ld_vld_i   (ex_q.vld && ex_q.dst_en && ex_q.mem_rd),
      .ex_dst_sel_i  (ex_q.dst_sel),
      .mem_wr_vld_i  (mem_q.vld && mem_q.dst_en),
      .mem_ld_i      (mem_q.mem_rd),
      .mem_dst_sel_i (mem_q.dst_sel),
      .wb_wr_vld_i   (wbs_q.wr),
      .wb_dst_sel_i  (wbs_q.dst_sel),
      .fwd_sel_o     (fwd[g]),
      .ld_use_o      (ld_use_op[g])
    );
  end

  assign ld_use    = |ld_use_op;
  assign fwd_sel_1 = fwd[0];
  assign fwd_sel_2 = fwd[1];

  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    if (!reset_n) begin
      pc_hold = 1'b0;
    end else if (frz) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      ex_mem_hold = 1'b1;
    end else if (kill) begin
      id_ex_bubble = 1'b1;
    end else if (ld_use) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wbs_d        = '0;
    tmr_d        = '0;
    flush_pend_d = 1'b0;
    mem_err_d    = mem_err_q;
    if (frz) begin
      // Upstream stages hold; WB drains into a bubble.
      flush_pend_d = flush_pend_q || flush;
      if (tmo) begin
        mem_d     = '0;
        mem_err_d = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end else begin
      wbs_d.wr      = mem_q.vld && mem_q.dst_en;
      wbs_d.dst_sel = mem_q.dst_sel;
      mem_d         = ex_q;
      ex_d          = '0;
      if (id_valid && !kill && !ld_use) begin
        ex_d.vld     = 1'b1;
        ex_d.dst_en  = id_dst_en;
        ex_d.dst_sel = id_dst_sel;
        ex_d.mem_rd  = id_mem_read;
        ex_d.mem_wr  = id_mem_write;
      end
    end
  end

  assign stall_cnt_d = (pc_hold && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wbs_q        <= '0;
      tmr_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_err_q    <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_sel_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wbs_q        <= wbs_d;
      tmr_q        <= tmr_d;
      flush_pend_q <= flush_pend_d;
      mem_err_q    <= mem_err_d;
      wb_en_q      <= wbs_q.wr;
      wb_sel_q     <= wbs_q.wr ? wbs_q.dst_sel : '0;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign wb_enable   = wb_en_q;
  assign wb_sel      = wb_sel_q;
  assign mem_error   = mem_err_q;
  assign stall_count = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized + directed bench; expected outputs come from an in-bench pipeline model and
// are queued per cycle, a separate monitor pops and compares them against the DUT.
module tb_pipeline_hazard_controller;
  localparam int RW = 2;
  localparam int TO = 16;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic id_valid = 0, id_src1_en = 0, id_src2_en = 0, id_dst_en = 0;
  logic id_mem_read = 0, id_mem_write = 0, flush = 0, mem_ready = 1;
  logic [RW-1:0] id_src1_sel = '0, id_src2_sel = '0, id_dst_sel = '0;
  logic pc_hold, if_id_hold, id_ex_bubble, ex_mem_hold, wb_enable, mem_error;
  logic [1:0] fwd_sel_1, fwd_sel_2;
  logic [RW-1:0] wb_sel;
  logic [CW-1:0] stall_count;

  always #5 clock = ~clock;

  pipeline_hazard_controller #(.REG_SEL_W(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_src1_en(id_src1_en), .id_src1_sel(id_src1_sel),
    .id_src2_en(id_src2_en), .id_src2_sel(id_src2_sel),
    .id_dst_en(id_dst_en), .id_dst_sel(id_dst_sel),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble),
    .ex_mem_hold(ex_mem_hold), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
    .wb_enable(wb_enable), .wb_sel(wb_sel), .mem_error(mem_error),
    .stall_count(stall_count)
  );

  typedef struct { bit v; bit de; bit [RW-1:0] ds; bit mr; bit mw; } ins_t;
  typedef struct { bit iv; bit s1e; bit [RW-1:0] s1; bit s2e; bit [RW-1:0] s2;
                   bit de; bit [RW-1:0] ds; bit mr; bit mw; } stim_t;
  typedef struct { bit ph; bit ih; bit bub; bit emh; bit [1:0] f1; bit [1:0] f2;
                   bit wbe; bit [RW-1:0] wbs; bit err; int cnt; } exp_t;

  exp_t exp_q[$];
  ins_t pipe[3];       // in-flight instructions: [0]=EX, [1]=MEM, [2]=WB
  int   m_tmr, m_cnt;
  bit   m_pend, m_err, m_wbe;
  bit [RW-1:0] m_wbs;
  int   checks = 0, failures = 0, cyc = 0;
  int   mem_stall_n = 0;  // hold mem_ready low for the next N cycles with an access in MEM
  bit   fl_next = 0, flush_in_frz = 0, last_hold = 0;

  function automatic stim_t mk(input bit iv, input bit s1e, input bit [RW-1:0] s1,
                               input bit s2e, input bit [RW-1:0] s2, input bit de,
                               input bit [RW-1:0] ds, input bit mr, input bit mw);
    stim_t s;
    s.iv = iv; s.s1e = s1e; s.s1 = s1; s.s2e = s2e; s.s2 = s2;
    s.de = de; s.ds = ds; s.mr = mr; s.mw = mw;
    return s;
  endfunction
  function automatic stim_t NOPI();
    return mk(0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0);
  endfunction
  function automatic stim_t ADD(input bit [RW-1:0] d, input bit [RW-1:0] a, input bit [RW-1:0] b);
    return mk(1, 1, a, 1, b, 1, d, 0, 0);
  endfunction
  function automatic stim_t LD(input bit [RW-1:0] d, input bit [RW-1:0] a);
    return mk(1, 1, a, 0, 2'd0, 1, d, 1, 0);
  endfunction

  function automatic bit hit(input ins_t i, input bit [RW-1:0] sel);
    return i.v && i.de && (i.ds == sel);
  endfunction
  function automatic bit [1:0] fwd_of(input bit en, input bit [RW-1:0] sel);
    if (!en) return 2'b00;
    if (hit(pipe[1], sel) && !pipe[1].mr) return 2'b01;
    if (hit(pipe[2], sel)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '{default:0};
    m_tmr = 0; m_cnt = 0; m_pend = 0; m_err = 0; m_wbe = 0; m_wbs = '0;
  endtask

  task automatic step(input stim_t s, input bit rst_n);
    exp_t e;
    bit acc, rdy, fl, frz, tmo, kill, lu, e1, e2;
    @(negedge clock);
    cyc++;
    fl  = fl_next; fl_next = 0;
    acc = pipe[1].v && (pipe[1].mr || pipe[1].mw);
    rdy = 1;
    if (rst_n && acc && mem_stall_n > 0) begin rdy = 0; mem_stall_n--; end
    if (rst_n && acc && !rdy && flush_in_frz) begin fl = 1; flush_in_frz = 0; end
    reset_n = rst_n; id_valid = s.iv; id_src1_en = s.s1e; id_src1_sel = s.s1;
    id_src2_en = s.s2e; id_src2_sel = s.s2; id_dst_en = s.de; id_dst_sel = s.ds;
    id_mem_read = s.mr; id_mem_write = s.mw; flush = fl; mem_ready = rdy;
    e = '{default:0};
    if (!rst_n) begin
      model_clear();
    end else begin
      frz  = acc && !rdy;
      tmo  = frz && (m_tmr == TO - 1);
      kill = !frz && (fl || m_pend);
      e1 = s.iv && s.s1e; e2 = s.iv && s.s2e;
      lu = 0;
      for (int k = 0; k < 2; k++)
        if (pipe[k].mr && ((e1 && hit(pipe[k], s.s1)) || (e2 && hit(pipe[k], s.s2)))) lu = 1;
      e.f1 = fwd_of(e1, s.s1); e.f2 = fwd_of(e2, s.s2);
      e.wbe = m_wbe; e.wbs = m_wbs; e.err = m_err; e.cnt = m_cnt;
      if (frz)       begin e.ph = 1; e.ih = 1; e.emh = 1; end
      else if (kill) e.bub = 1;
      else if (lu)   begin e.ph = 1; e.ih = 1; e.bub = 1; end
      // advance the model across the coming rising edge
      if (e.ph && m_cnt < (1 << CW) - 1) m_cnt++;
      m_wbe = pipe[2].v && pipe[2].de;
      m_wbs = m_wbe ? pipe[2].ds : '0;
      if (frz) begin
        m_pend |= fl;
        pipe[2] = '{default:0};
        if (tmo) begin pipe[1] = '{default:0}; m_err = 1; m_tmr = 0; end
        else m_tmr++;
      end else begin
        m_tmr = 0; m_pend = 0;
        pipe[2] = pipe[1]; pipe[1] = pipe[0];
        if (kill || lu || !s.iv) pipe[0] = '{default:0};
        else pipe[0] = '{1'b1, s.de, s.ds, s.mr, s.mw};
      end
    end
    exp_q.push_back(e);
    last_hold = e.ih;
  endtask

  // Present one instruction in ID, re-presenting it while IF/ID is held.
  task automatic issue(input stim_t s);
    int n = 0;
    do begin step(s, 1'b1); n++; end while (last_hold && n < 64);
    checks++;
    if (last_hold) begin
      failures++;
      $display("FAIL hold_bound actual=held_%0d_cycles required=release", n);
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock); #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_hold",      int'(pc_hold),      int'(e.ph));
        chk("if_id_hold",   int'(if_id_hold),   int'(e.ih));
        chk("id_ex_bubble", int'(id_ex_bubble), int'(e.bub));
        chk("ex_mem_hold",  int'(ex_mem_hold),  int'(e.emh));
        chk("fwd_sel_1",    int'(fwd_sel_1),    int'(e.f1));
        chk("fwd_sel_2",    int'(fwd_sel_2),    int'(e.f2));
        chk("wb_enable",    int'(wb_enable),    int'(e.wbe));
        chk("wb_sel",       int'(wb_sel),       int'(e.wbs));
        chk("mem_error",    int'(mem_error),    int'(e.err));
        chk("stall_count",  int'(stall_count),  e.cnt);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    stim_t s;
    model_clear();
    for (int i = 0; i < 3; i++) step(ADD(2'd1, 2'd1, 2'd1), 1'b0);
    // forwarding from MEM then WB
    issue(ADD(2'd1, 2'd2, 2'd3)); issue(NOPI()); issue(ADD(2'd2, 2'd1, 2'd0));
    issue(ADD(2'd3, 2'd0, 2'd0)); issue(NOPI()); issue(NOPI()); issue(ADD(2'd0, 2'd3, 2'd3));
    // load-use: one gap and back-to-back
    issue(LD(2'd2, 2'd0)); issue(NOPI()); issue(ADD(2'd1, 2'd2, 2'd0));
    issue(LD(2'd2, 2'd0)); issue(ADD(2'd1, 2'd0, 2'd2));
    for (int i = 0; i < 4; i++) issue(NOPI());
    // 3-cycle memory wait, then a timeout
    mem_stall_n = 3;  issue(LD(2'd3, 2'd1)); for (int i = 0; i < 5; i++) issue(NOPI());
    mem_stall_n = TO; issue(LD(2'd1, 2'd0)); issue(ADD(2'd2, 2'd0, 2'd0));
    for (int i = 0; i < 5; i++) issue(NOPI());
    // flush raised during a freeze
    mem_stall_n = 4; flush_in_frz = 1;
    issue(LD(2'd1, 2'd0)); issue(ADD(2'd2, 2'd3, 2'd3)); issue(ADD(2'd3, 2'd0, 2'd0));
    for (int i = 0; i < 5; i++) issue(NOPI());
    // reset mid-freeze, then an ADD completes normally
    mem_stall_n = 10;
    step(LD(2'd2, 2'd0), 1'b1); step(NOPI(), 1'b1); step(NOPI(), 1'b1); step(NOPI(), 1'b1);
    step(NOPI(), 1'b0); mem_stall_n = 0; flush_in_frz = 0;
    issue(ADD(2'd3, 2'd1, 2'd2)); for (int i = 0; i < 4; i++) issue(NOPI());
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s = mk(1'($urandom), 1'($urandom), RW'($urandom), 1'($urandom), RW'($urandom),
             1'($urandom), RW'($urandom), 1'b0, 1'b0);
      case ($urandom_range(0, 3))
        0: s.iv = 0;
        1: begin s.mr = 1; s.iv = 1; end
        2: begin s.mw = 1; s.de = 0; s.iv = 1; end
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) fl_next = 1;
      if ($urandom_range(0, 24) == 0) mem_stall_n = $urandom_range(1, 20);
      if ($urandom_range(0, 39) == 0) flush_in_frz = 1;
      issue(s);
    end
    mem_stall_n = 0;
    for (int i = 0; i < 4; i++) issue(NOPI());
    @(negedge clock); #4;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
